// File: rtl/mac_accum_multichan_if.sv
// Valid/ready beat and result bus of the multichannel MAC engine.
interface mac_accum_multichan_if #(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned CH_W      = 2
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [CH_W-1:0]      in_ch;
    logic                 in_first;
    logic                 in_last;
    logic [A_WIDTH-1:0]   a;
    logic [B_WIDTH-1:0]   b;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH_W-1:0]      out_ch;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_sat;
    logic                 busy;

    modport master (
        output in_valid, in_ch, in_first, in_last, a, b, out_ready,
        input  in_ready, out_valid, out_ch, out_data, out_sat, busy
    );

    modport slave (
        input  in_valid, in_ch, in_first, in_last, a, b, out_ready,
        output in_ready, out_valid, out_ch, out_data, out_sat, busy
    );
endinterface

// File: rtl/mac_accum_multichan.sv
// Pipelined signed MAC with NUM_CH framed accumulators sharing one multiplier;
// last beat of a frame is rounded, shifted and saturated into the output stage.
module mac_accum_multichan #(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned SHIFT     = 0,
    parameter int unsigned NUM_CH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mac_accum_multichan_if.slave    bus
);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PROD_W = A_WIDTH + B_WIDTH;
    localparam int unsigned RW     = ACC_WIDTH + 1;
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] RND     = (SHIFT > 0) ? (RW'(1) << RND_SH) : '0;
    localparam logic signed [RW-1:0] OUT_MAX = RW'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [RW-1:0] OUT_MIN = ~OUT_MAX;

    logic stall_c, accept_c, ch_ok_c;

    logic                        s1_valid_q, s1_first_q, s1_last_q;
    logic [CH_W-1:0]             s1_ch_q;
    logic signed [A_WIDTH-1:0]   s1_a_q;
    logic signed [B_WIDTH-1:0]   s1_b_q;

    logic                        s2_valid_q, s2_first_q, s2_last_q;
    logic [CH_W-1:0]             s2_ch_q;
    logic signed [ACC_WIDTH-1:0] s2_prod_q, s2_prod_d;
    logic signed [PROD_W-1:0]    prod_full_c;

    logic                        s3_valid_q, s3_last_q;
    logic [CH_W-1:0]             s3_ch_q;
    logic signed [ACC_WIDTH-1:0] s3_sum_q, sum_d, acc_sel_c;

    logic [ACC_WIDTH-1:0]        acc_q [NUM_CH];
    logic [ACC_WIDTH-1:0]        acc_d [NUM_CH];

    logic signed [RW-1:0]        sum_ext_c, rnd_c, shr_c;
    logic                        out_valid_q, out_valid_d;
    logic [CH_W-1:0]             out_ch_q, out_ch_d;
    logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;

    // A pending unaccepted result freezes the whole engine
    assign stall_c  = out_valid_q && !bus.out_ready;
    assign accept_c = bus.in_valid && !stall_c;
    assign ch_ok_c  = {1'b0, bus.in_ch} < (CH_W+1)'(NUM_CH);

    assign prod_full_c = PROD_W'(s1_a_q) * PROD_W'(s1_b_q);
    assign s2_prod_d   = ACC_WIDTH'(prod_full_c);

    // Accumulator read-modify-write; the new value is forwarded as the frame sum
    always_comb begin
        acc_sel_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (s2_ch_q == CH_W'(i)) acc_sel_c = acc_q[i];
        end
        sum_d = s2_first_q ? s2_prod_q : acc_sel_c + s2_prod_q;
        acc_d = acc_q;
        if (s2_valid_q) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (s2_ch_q == CH_W'(i)) acc_d[i] = sum_d;
            end
        end
    end

    // Round half up, arithmetic shift, clip to the output range
    always_comb begin
        sum_ext_c   = RW'(s3_sum_q);
        rnd_c       = sum_ext_c + RND;
        shr_c       = rnd_c >>> SHIFT;
        out_valid_d = s3_valid_q && s3_last_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (out_valid_d) begin
            out_ch_d = s3_ch_q;
            if (shr_c > OUT_MAX) begin
                out_data_d = OUT_MAX[OUT_WIDTH-1:0];
                out_sat_d  = 1'b1;
            end else if (shr_c < OUT_MIN) begin
                out_data_d = OUT_MIN[OUT_WIDTH-1:0];
                out_sat_d  = 1'b1;
            end else begin
                out_data_d = shr_c[OUT_WIDTH-1:0];
                out_sat_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_ch_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_ch_q     <= '0;
            s2_prod_q   <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_ch_q     <= '0;
            s3_sum_q    <= '0;
            acc_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (!stall_c) begin
            // Out-of-range channels are dropped at the door
            s1_valid_q  <= accept_c && ch_ok_c;
            s1_first_q  <= bus.in_first;
            s1_last_q   <= bus.in_last;
            s1_ch_q     <= bus.in_ch;
            s1_a_q      <= bus.a;
            s1_b_q      <= bus.b;
            s2_valid_q  <= s1_valid_q;
            s2_first_q  <= s1_first_q;
            s2_last_q   <= s1_last_q;
            s2_ch_q     <= s1_ch_q;
            s2_prod_q   <= s2_prod_d;
            s3_valid_q  <= s2_valid_q;
            s3_last_q   <= s2_last_q;
            s3_ch_q     <= s2_ch_q;
            s3_sum_q    <= sum_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = !stall_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.busy      = s1_valid_q || s2_valid_q || s3_valid_q || out_valid_q;
endmodule

// File: tb/tb_mac_accum_multichan.sv
// Scoreboard bench: dut0 (SHIFT=0, 4 channels) and dut1 (SHIFT=15, 3 channels).
module tb_mac_accum_multichan;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_accum_multichan_if #(.CH_W(2)) if0 ();
    mac_accum_multichan_if #(.CH_W(2)) if1 ();

    mac_accum_multichan #(.SHIFT(0), .NUM_CH(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mac_accum_multichan #(.SHIFT(15), .NUM_CH(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
        logic        sat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int checks = 0;
    int errors = 0;
    int n;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit d1, input int ch, input int data, input bit sat);
        exp_t e;
        e.ch = 2'(ch);
        e.data = 32'(data);
        e.sat = sat;
        if (d1) q1.push_back(e);
        else    q0.push_back(e);
    endtask

    // Drive one beat and hold it until the engine takes it
    task automatic beat(input bit d1, input int ch, input int av, input int bv,
                        input bit f, input bit l);
        int k;
        k = 0;
        if (!d1) begin
            if0.in_valid = 1'b1; if0.in_ch = 2'(ch); if0.a = 16'(av); if0.b = 16'(bv);
            if0.in_first = f; if0.in_last = l;
        end else begin
            if1.in_valid = 1'b1; if1.in_ch = 2'(ch); if1.a = 16'(av); if1.b = 16'(bv);
            if1.in_first = f; if1.in_last = l;
        end
        while (!(d1 ? if1.in_ready : if0.in_ready) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            checks++; errors++;
            $display("FAIL beat_timeout in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || if0.busy || if1.busy) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending got %0d expected 0", q0.size() + q1.size());
        end
    endtask

    task automatic reset_checks();
        chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_out_data",  64'(if0.out_data),  64'd0);
        chk("rst_out_ch",    64'(if0.out_ch),    64'd0);
        chk("rst_out_sat",   64'(if0.out_sat),   64'd0);
        chk("rst_busy",      64'(if0.busy),      64'd0);
        chk("rst_in_ready",  64'(if0.in_ready),  64'd1);
        chk("rst_in_ready1", 64'(if1.in_ready),  64'd1);
    endtask

    // Monitors: pop and compare on every output handshake
    always @(negedge clk) begin
        if (!rst && if0.out_valid && if0.out_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL out0_unexpected got ch %0d data %0h expected none",
                         if0.out_ch, if0.out_data);
            end else begin
                e0 = q0.pop_front();
                chk("out0_data", 64'(if0.out_data), 64'(e0.data));
                chk("out0_ch",   64'(if0.out_ch),   64'(e0.ch));
                chk("out0_sat",  64'(if0.out_sat),  64'(e0.sat));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if1.out_valid && if1.out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL out1_unexpected got ch %0d data %0h expected none",
                         if1.out_ch, if1.out_data);
            end else begin
                e1 = q1.pop_front();
                chk("out1_data", 64'(if1.out_data), 64'(e1.data));
                chk("out1_ch",   64'(if1.out_ch),   64'(e1.ch));
                chk("out1_sat",  64'(if1.out_sat),  64'(e1.sat));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        if0.in_valid = 1'b0; if0.in_ch = '0; if0.in_first = 1'b0; if0.in_last = 1'b0;
        if0.a = '0; if0.b = '0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_ch = '0; if1.in_first = 1'b0; if1.in_last = 1'b0;
        if1.a = '0; if1.b = '0; if1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        reset_checks();

        // Two-beat frame on ch0 and its latency
        push(0, 0, 42, 0);
        beat(0, 0, 3, 4, 1, 0);
        beat(0, 0, 5, 6, 0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_not_yet", 64'(if0.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_valid", 64'(if0.out_valid), 64'd1);
        drain();

        // Interleaved channels
        push(0, 1, 8, 0);
        push(0, 2, -20, 0);
        beat(0, 1, 2, 2, 1, 0);
        beat(0, 2, -7, 3, 1, 0);
        beat(0, 1, 2, 2, 0, 1);
        beat(0, 2, 1, 1, 0, 1);
        drain();

        // Positive and negative saturation
        push(0, 0, 32'h7FFF_FFFF, 1);
        beat(0, 0, -32768, -32768, 1, 0);
        beat(0, 0, -32768, -32768, 0, 0);
        beat(0, 0, -32768, -32768, 0, 0);
        beat(0, 0, -32768, -32768, 0, 1);
        push(0, 3, 32'h8000_0000, 1);
        beat(0, 3, -32768, 32767, 1, 0);
        beat(0, 3, -32768, 32767, 0, 0);
        beat(0, 3, -32768, 32767, 0, 1);
        drain();

        // Back-to-back same channel; first overwrites the saturated history
        push(0, 0, -15, 0);
        beat(0, 0, 1, 1, 1, 0);
        beat(0, 0, 2, 3, 0, 0);
        beat(0, 0, 4, 5, 0, 0);
        beat(0, 0, -6, 7, 0, 1);
        drain();

        // Backpressure with three results pending
        if0.out_ready = 1'b0;
        push(0, 0, 2, 0);
        push(0, 1, 12, 0);
        push(0, 2, 30, 0);
        beat(0, 0, 1, 2, 1, 1);
        beat(0, 1, 3, 4, 1, 1);
        beat(0, 2, 5, 6, 1, 1);
        n = 0;
        while (!if0.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("stall_in_ready",  64'(if0.in_ready),  64'd0);
        chk("stall_out_valid", 64'(if0.out_valid), 64'd1);
        chk("stall_out_data",  64'(if0.out_data),  64'd2);
        chk("stall_out_ch",    64'(if0.out_ch),    64'd0);
        chk("stall_busy",      64'(if0.busy),      64'd1);
        if0.out_ready = 1'b1;
        drain();

        // SHIFT=15 rounding and out-of-range channel discard
        beat(1, 3, 5, 5, 1, 1);
        push(1, 0, 2, 0);
        beat(1, 0, 3, 16384, 1, 1);
        push(1, 1, -1, 0);
        beat(1, 1, -3, 16384, 1, 1);
        drain();

        // Reset mid-frame clears the accumulator
        beat(0, 3, 100, 100, 1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_checks();
        push(0, 3, 1, 0);
        beat(0, 3, 1, 1, 0, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
